// File: rtl/lu_row_mem.sv
// lu_row_mem: synthesizable row store opposite the lu engine's row port.
// Loads SIZE rows from a host stream, pulses engine_start_o, serves 1-cycle
// row reads and accepts row writebacks, then streams the matrix back to the
// host after engine_done_i.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (abort to IDLE)
//   load_row_i/load_valid_i/load_ready_o          host row input
//   engine_start_o/engine_done_i                  engine control
//   rd_addr_i/rd_addr_valid_i -> rd_row_o/rd_row_addr_o/rd_row_valid_o
//   wr_row_i/wr_addr_i/wr_valid_i/wr_ready_o      engine writeback
//   out_row_o/out_addr_o/out_valid_o/out_last_o/out_ready_i  result stream
//   err_o (sticky out-of-range address), busy_o (not IDLE)
module lu_row_mem #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = $clog2(SIZE)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [SIZE*2*WIDTH-1:0] load_row_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  output logic                    engine_start_o,
  input  logic                    engine_done_i,
  input  logic [AW-1:0]           rd_addr_i,
  input  logic                    rd_addr_valid_i,
  output logic [SIZE*2*WIDTH-1:0] rd_row_o,
  output logic [AW-1:0]           rd_row_addr_o,
  output logic                    rd_row_valid_o,
  input  logic [SIZE*2*WIDTH-1:0] wr_row_i,
  input  logic [AW-1:0]           wr_addr_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  output logic [SIZE*2*WIDTH-1:0] out_row_o,
  output logic [AW-1:0]           out_addr_o,
  output logic                    out_valid_o,
  output logic                    out_last_o,
  input  logic                    out_ready_i,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int unsigned RW = SIZE * 2 * WIDTH;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SERVE, S_DUMP} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [RW-1:0]   mem [SIZE];

  logic            rd_oor_c, wr_oor_c;
  logic            load_hs_c, wr_fire_c, rd_fire_c, out_hs_c, cnt_last_c;
  logic            mem_we_c;
  logic [AW-1:0]   mem_addr_c;
  logic [RW-1:0]   mem_wdata_c;
  logic [RW-1:0]   rd_data_c;
  logic [RW-1:0]   dump_first_c;
  logic [AW-1:0]   next_addr_c;

  // Handshake qualification, write-first forwarding and the single memory write port
  always_comb begin
    rd_oor_c     = ({1'b0, rd_addr_i} >= CW'(SIZE));
    wr_oor_c     = ({1'b0, wr_addr_i} >= CW'(SIZE));
    load_hs_c    = load_valid_i && load_ready_o &&
                   ((state_q == S_IDLE) || (state_q == S_LOAD));
    wr_fire_c    = (state_q == S_SERVE) && wr_valid_i && wr_ready_o && !wr_oor_c;
    rd_fire_c    = (state_q == S_SERVE) && rd_addr_valid_i && !rd_oor_c;
    out_hs_c     = (state_q == S_DUMP) && out_valid_o && out_ready_i;
    cnt_last_c   = (cnt_q == CW'(SIZE - 1));
    next_addr_c  = cnt_q[AW-1:0] + AW'(1);
    rd_data_c    = (wr_fire_c && (wr_addr_i == rd_addr_i)) ? wr_row_i : mem[rd_addr_i];
    dump_first_c = (wr_fire_c && (wr_addr_i == AW'(0))) ? wr_row_i : mem[AW'(0)];

    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (!rst_i && !flush_i) begin
      if (load_hs_c) begin
        mem_we_c    = 1'b1;
        mem_addr_c  = cnt_q[AW-1:0];
        mem_wdata_c = load_row_i;
      end else if (wr_fire_c) begin
        mem_we_c    = 1'b1;
        mem_addr_c  = wr_addr_i;
        mem_wdata_c = wr_row_i;
      end
    end
  end

  // Row storage; contents intentionally survive reset
  always_ff @(posedge clk_i) begin
    if (mem_we_c) mem[mem_addr_c] <= mem_wdata_c;
  end

  // Control state machine with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      load_ready_o   <= 1'b0;
      engine_start_o <= 1'b0;
      rd_row_valid_o <= 1'b0;
      rd_row_o       <= '0;
      rd_row_addr_o  <= '0;
      wr_ready_o     <= 1'b0;
      out_valid_o    <= 1'b0;
      out_last_o     <= 1'b0;
      out_row_o      <= '0;
      out_addr_o     <= '0;
      err_o          <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      engine_start_o <= 1'b0;
      rd_row_valid_o <= 1'b0;
      if (flush_i) begin
        state_q      <= S_IDLE;
        cnt_q        <= '0;
        load_ready_o <= 1'b1;
        wr_ready_o   <= 1'b0;
        out_valid_o  <= 1'b0;
        out_last_o   <= 1'b0;
        busy_o       <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_LOAD: begin
            load_ready_o <= 1'b1;
            if (load_hs_c) begin
              busy_o <= 1'b1;
              if (cnt_last_c) begin
                // Last row stored: hand the matrix to the engine
                state_q        <= S_SERVE;
                cnt_q          <= '0;
                load_ready_o   <= 1'b0;
                engine_start_o <= 1'b1;
                wr_ready_o     <= 1'b1;
              end else begin
                state_q <= S_LOAD;
                cnt_q   <= cnt_q + CW'(1);
              end
            end
          end
          S_SERVE: begin
            if (rd_fire_c) begin
              rd_row_valid_o <= 1'b1;
              rd_row_o       <= rd_data_c;
              rd_row_addr_o  <= rd_addr_i;
            end
            if ((rd_addr_valid_i && rd_oor_c) || (wr_valid_i && wr_ready_o && wr_oor_c))
              err_o <= 1'b1;
            if (engine_done_i) begin
              // Present row 0 immediately, including a coincident writeback to it
              state_q     <= S_DUMP;
              cnt_q       <= '0;
              wr_ready_o  <= 1'b0;
              out_valid_o <= 1'b1;
              out_row_o   <= dump_first_c;
              out_addr_o  <= '0;
              out_last_o  <= 1'b0;
            end
          end
          S_DUMP: begin
            if (out_hs_c) begin
              if (cnt_last_c) begin
                state_q      <= S_IDLE;
                cnt_q        <= '0;
                out_valid_o  <= 1'b0;
                out_last_o   <= 1'b0;
                busy_o       <= 1'b0;
                load_ready_o <= 1'b1;
              end else begin
                cnt_q      <= cnt_q + CW'(1);
                out_row_o  <= mem[next_addr_c];
                out_addr_o <= next_addr_c;
                out_last_o <= (cnt_q == CW'(SIZE - 2));
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lu_row_mem.sv
// Self-checking bench for lu_row_mem: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the row store.
module tb_lu_row_mem;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned AW    = 2;
  localparam int unsigned RW    = SIZE * 2 * WIDTH;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i;
  logic [RW-1:0] load_row_i, wr_row_i;
  logic          load_valid_i, engine_done_i, rd_addr_valid_i, wr_valid_i, out_ready_i;
  logic [AW-1:0] rd_addr_i, wr_addr_i;
  logic          load_ready_o, engine_start_o, rd_row_valid_o, wr_ready_o;
  logic          out_valid_o, out_last_o, err_o, busy_o;
  logic [RW-1:0] rd_row_o, out_row_o;
  logic [AW-1:0] rd_row_addr_o, out_addr_o;

  int nvec = 0;
  int nerr = 0;

  lu_row_mem #(.SIZE(SIZE), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .load_row_i(load_row_i), .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .engine_start_o(engine_start_o), .engine_done_i(engine_done_i),
    .rd_addr_i(rd_addr_i), .rd_addr_valid_i(rd_addr_valid_i),
    .rd_row_o(rd_row_o), .rd_row_addr_o(rd_row_addr_o), .rd_row_valid_o(rd_row_valid_o),
    .wr_row_i(wr_row_i), .wr_addr_i(wr_addr_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .out_row_o(out_row_o), .out_addr_o(out_addr_o), .out_valid_o(out_valid_o),
    .out_last_o(out_last_o), .out_ready_i(out_ready_i),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_int(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_row(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < int'(RW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [RW-1:0] pat_row(input int k);
    logic [RW-1:0] r;
    for (int i = 0; i < int'(RW / 32); i++) r[i*32 +: 32] = 32'h1111_1111 * (k + 1) + i;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 loading, 2 serving the engine, 3 dumping results
  int            mode = 0;
  int            idx  = 0;
  logic [RW-1:0] mrow [SIZE];
  logic          e_load_ready, e_start, e_rd_valid, e_wr_ready, e_out_valid, e_out_last;
  logic          e_err, e_busy, after_reset;
  logic [RW-1:0] e_rd_row, e_out_row;
  int            e_rd_addr, e_out_addr;

  task automatic present(input int k);
    e_out_row  = mrow[k];
    e_out_addr = k;
    e_out_last = (k == int'(SIZE) - 1);
  endtask

  task automatic model_step();
    logic hs, wr;
    if (rst_i) begin
      mode = 0; idx = 0; after_reset = 1'b1;
      {e_load_ready, e_start, e_rd_valid, e_wr_ready, e_out_valid, e_out_last, e_err, e_busy} = '0;
      e_rd_row = '0; e_out_row = '0; e_rd_addr = 0; e_out_addr = 0;
      return;
    end
    after_reset = 1'b0;
    e_start    = 1'b0;
    e_rd_valid = 1'b0;
    if (flush_i) begin
      mode = 0; idx = 0;
      e_load_ready = 1'b1; e_wr_ready = 1'b0; e_out_valid = 1'b0;
      e_out_last = 1'b0; e_busy = 1'b0;
      return;
    end
    case (mode)
      0, 1: begin
        hs = load_valid_i && e_load_ready;
        e_load_ready = 1'b1;
        if (hs) begin
          mrow[idx] = load_row_i;
          idx++;
          mode = 1; e_busy = 1'b1;
          if (idx == int'(SIZE)) begin
            mode = 2; idx = 0;
            e_load_ready = 1'b0; e_start = 1'b1; e_wr_ready = 1'b1;
          end
        end
      end
      2: begin
        wr = wr_valid_i && e_wr_ready && (int'(wr_addr_i) < int'(SIZE));
        if (rd_addr_valid_i && int'(rd_addr_i) < int'(SIZE)) begin
          e_rd_valid = 1'b1;
          e_rd_addr  = int'(rd_addr_i);
          e_rd_row   = (wr && wr_addr_i == rd_addr_i) ? wr_row_i : mrow[rd_addr_i];
        end
        if ((rd_addr_valid_i && int'(rd_addr_i) >= int'(SIZE)) ||
            (wr_valid_i && int'(wr_addr_i) >= int'(SIZE))) e_err = 1'b1;
        if (wr) mrow[wr_addr_i] = wr_row_i;
        if (engine_done_i) begin
          mode = 3; idx = 0;
          e_wr_ready = 1'b0; e_out_valid = 1'b1;
          present(0);
        end
      end
      default: begin
        if (out_ready_i && e_out_valid) begin
          idx++;
          if (idx == int'(SIZE)) begin
            mode = 0; idx = 0;
            e_out_valid = 1'b0; e_out_last = 1'b0; e_busy = 1'b0; e_load_ready = 1'b1;
          end else present(idx);
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk_int("load_ready", 32'(load_ready_o), 32'(e_load_ready));
    chk_int("engine_start", 32'(engine_start_o), 32'(e_start));
    chk_int("rd_valid", 32'(rd_row_valid_o), 32'(e_rd_valid));
    if (e_rd_valid || after_reset) begin
      chk_row("rd_row", rd_row_o, e_rd_row);
      chk_int("rd_addr", 32'(rd_row_addr_o), 32'(e_rd_addr));
    end
    chk_int("wr_ready", 32'(wr_ready_o), 32'(e_wr_ready));
    chk_int("out_valid", 32'(out_valid_o), 32'(e_out_valid));
    if (e_out_valid || after_reset) begin
      chk_row("out_row", out_row_o, e_out_row);
      chk_int("out_addr", 32'(out_addr_o), 32'(e_out_addr));
      chk_int("out_last", 32'(out_last_o), 32'(e_out_last));
    end
    chk_int("err", 32'(err_o), 32'(e_err));
    chk_int("busy", 32'(busy_o), 32'(e_busy));
  endtask

  // Model advances on each edge; DUT compared 1 ns later
  always @(posedge clk_i) begin
    model_step();
    #1;
    compare_all();
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    flush_i = 0; load_valid_i = 0; engine_done_i = 0; rd_addr_valid_i = 0;
    wr_valid_i = 0; out_ready_i = 0;
  endtask

  logic [RW-1:0] drow [SIZE];
  logic [RW-1:0] a5_row;

  initial begin
    rst_i = 1; idle_inputs();
    load_row_i = '0; wr_row_i = '0; rd_addr_i = '0; wr_addr_i = '0;
    a5_row = {(RW/8){8'hA5}};
    for (int k = 0; k < int'(SIZE); k++) drow[k] = pat_row(k);
    cyc(); cyc();
    chk_int("reset_busy", 32'(busy_o), 32'd0);
    chk_int("reset_out_row_lsw", 32'(out_row_o[31:0]), 32'd0);
    rst_i = 0;
    cyc(); cyc();

    // Load four distinct rows back to back
    for (int k = 0; k < int'(SIZE); k++) begin
      load_valid_i = 1; load_row_i = drow[k]; cyc();
    end
    load_valid_i = 0;
    chk_int("start_pulse", 32'(engine_start_o), 32'd1);
    chk_int("ready_dropped", 32'(load_ready_o), 32'd0);
    cyc();
    chk_int("start_one_cycle", 32'(engine_start_o), 32'd0);

    // Back-to-back reads 2,0,3
    rd_addr_valid_i = 1; rd_addr_i = 2'd2; cyc();
    chk_row("rd2", rd_row_o, drow[2]); chk_int("rd2_addr", 32'(rd_row_addr_o), 32'd2);
    rd_addr_i = 2'd0; cyc();
    chk_row("rd0", rd_row_o, drow[0]); chk_int("rd0_valid", 32'(rd_row_valid_o), 32'd1);
    rd_addr_i = 2'd3; cyc();
    chk_row("rd3", rd_row_o, drow[3]); chk_int("rd3_addr", 32'(rd_row_addr_o), 32'd3);
    rd_addr_valid_i = 0;

    // Write-first on address 1, then a later read of the same row
    wr_valid_i = 1; wr_addr_i = 2'd1; wr_row_i = a5_row;
    rd_addr_valid_i = 1; rd_addr_i = 2'd1; cyc();
    chk_row("write_first", rd_row_o, a5_row);
    wr_valid_i = 0; cyc();
    chk_row("reread_a5", rd_row_o, a5_row);
    rd_addr_valid_i = 0;

    // Dump with backpressure on row 2
    engine_done_i = 1; cyc(); engine_done_i = 0;
    out_ready_i = 1;
    chk_row("dump0", out_row_o, drow[0]); chk_int("dump0_addr", 32'(out_addr_o), 32'd0);
    cyc();
    chk_row("dump1", out_row_o, a5_row); chk_int("dump1_last", 32'(out_last_o), 32'd0);
    cyc();
    out_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      chk_row("hold_row2", out_row_o, drow[2]);
      chk_int("hold_addr2", 32'(out_addr_o), 32'd2);
      cyc();
    end
    out_ready_i = 1;
    chk_row("dump2", out_row_o, drow[2]); cyc();
    chk_row("dump3", out_row_o, drow[3]);
    chk_int("dump3_last", 32'(out_last_o), 32'd1); cyc();
    out_ready_i = 0;
    chk_int("dump_end_valid", 32'(out_valid_o), 32'd0);
    chk_int("dump_end_busy", 32'(busy_o), 32'd0);

    // Flush after two load handshakes, then a full reload
    for (int k = 0; k < 2; k++) begin
      load_valid_i = 1; load_row_i = rand_row(); cyc();
    end
    flush_i = 1; cyc();
    flush_i = 0; load_valid_i = 0;
    chk_int("flush_busy", 32'(busy_o), 32'd0);
    chk_int("flush_no_start", 32'(engine_start_o), 32'd0);
    for (int k = 0; k < int'(SIZE); k++) begin
      load_valid_i = 1; load_row_i = rand_row(); cyc();
    end
    load_valid_i = 0;
    chk_int("reload_start", 32'(engine_start_o), 32'd1);

    // Reset while a read is pending in SERVE
    rd_addr_valid_i = 1; rd_addr_i = 2'd0; rst_i = 1; cyc();
    chk_int("rst_rd_valid", 32'(rd_row_valid_o), 32'd0);
    chk_int("rst_busy", 32'(busy_o), 32'd0);
    chk_int("rst_err", 32'(err_o), 32'd0);
    rst_i = 0; rd_addr_valid_i = 0; cyc(); cyc();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst_i           = ($urandom_range(0, 299) == 0);
      flush_i         = ($urandom_range(0, 99) == 0);
      load_valid_i    = ($urandom_range(0, 9) < 7);
      load_row_i      = rand_row();
      rd_addr_valid_i = $urandom_range(0, 1) == 1;
      rd_addr_i       = AW'($urandom_range(0, SIZE - 1));
      wr_valid_i      = ($urandom_range(0, 9) < 4);
      wr_addr_i       = AW'($urandom_range(0, SIZE - 1));
      wr_row_i        = ($urandom_range(0, 3) == 0) ? a5_row : rand_row();
      engine_done_i   = ($urandom_range(0, 29) == 0);
      out_ready_i     = ($urandom_range(0, 9) < 6);
      cyc();
    end
    rst_i = 0; idle_inputs(); cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
